// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi: prescaled seconds-of-day counter with
// NUM_ALARMS latched alarm channels, each with ack and snooze.
module alarm_clock_multi #(
  parameter int CLKS_PER_SEC = 2,
  parameter int SECS_PER_DAY = 86400,
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_SECS = 540,
  localparam int CW = $clog2(SECS_PER_DAY),
  localparam int AW = (NUM_ALARMS > 1) ?
    $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  set_flag,
  input  logic [CW-1:0]         set_time,
  input  logic                  alarm_wr,
  input  logic [AW-1:0]         alarm_sel,
  input  logic                  alarm_en_in,
  input  logic [CW-1:0]         alarm_time_in,
  input  logic [NUM_ALARMS-1:0] alarm_ack,
  input  logic [NUM_ALARMS-1:0] alarm_snooze,
  output logic [CW-1:0]         counter_state,
  output logic                  sec_tick,
  output logic                  day_wrap,
  output logic [NUM_ALARMS-1:0] alarm_state,
  output logic                  alarm_any
);

  localparam int PW = (CLKS_PER_SEC > 1) ?
    $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PS_LAST =
    PW'(CLKS_PER_SEC - 1);
  localparam logic [CW-1:0] LAST =
    CW'(SECS_PER_DAY - 1);
  localparam logic [CW:0] DAY =
    (CW+1)'(SECS_PER_DAY);
  localparam logic [CW:0] SNZ =
    (CW+1)'(SNOOZE_SECS);

  logic [PW-1:0] presc_q;
  logic          tick;
  logic          at_last;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] set_val;
  logic [CW:0]   snz_sum;
  logic [CW:0]   snz_mod;
  logic          time_ok;

  // Next-value and tick decode shared by counter and channels
  always_comb begin
    tick = (presc_q == PS_LAST) && !set_flag;
    at_last = (counter_state == LAST);
    cnt_inc = at_last ? '0 : counter_state + CW'(1);
    set_val = ({1'b0, set_time} >= DAY) ?
      '0 : set_time;
    snz_sum = {1'b0, counter_state} + SNZ;
    snz_mod = (snz_sum >= DAY) ?
      snz_sum - DAY : snz_sum;
    time_ok = ({1'b0, alarm_time_in} < DAY);
  end

  // Prescaler: restarts on every set cycle and every tick
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if (set_flag || presc_q == PS_LAST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Seconds counter with registered tick/wrap pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter_state <= '0;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      sec_tick <= tick;
      day_wrap <= tick && at_last;
      if (set_flag) begin
        counter_state <= set_val;
      end else if (tick) begin
        counter_state <= cnt_inc;
      end
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    localparam logic [AW-1:0] IDX = AW'(i);

    logic          en_q;
    logic          st_q;
    logic          pend_q;
    logic [CW-1:0] at_q;
    logic [CW-1:0] sn_q;
    logic          wr_hit;
    logic          hit;
    logic          snz_hit;

    // Channel decode: config write, alarm match, snooze target
    always_comb begin
      wr_hit = alarm_wr && (alarm_sel == IDX);
      hit = tick && en_q && (cnt_inc == at_q);
      snz_hit = tick && pend_q && (cnt_inc == sn_q);
    end

    // Channel state: write > ring > ack > snooze
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        en_q <= 1'b0;
        st_q <= 1'b0;
        pend_q <= 1'b0;
        at_q <= '0;
        sn_q <= '0;
      end else if (wr_hit) begin
        en_q <= alarm_en_in && time_ok;
        at_q <= alarm_time_in;
        st_q <= 1'b0;
        pend_q <= 1'b0;
      end else if (hit || snz_hit) begin
        st_q <= 1'b1;
        if (snz_hit) begin
          pend_q <= 1'b0;
        end
      end else if (alarm_ack[i]) begin
        st_q <= 1'b0;
        pend_q <= 1'b0;
      end else if (alarm_snooze[i] && st_q) begin
        st_q <= 1'b0;
        pend_q <= 1'b1;
        sn_q <= snz_mod[CW-1:0];
      end
    end

    assign alarm_state[i] = st_q;
  end

  assign alarm_any = |alarm_state;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// tb_alarm_clock_multi: directed checks of counter, set,
// alarm match, ack, snooze, day wrap and async reset.
module tb_alarm_clock_multi;

  logic        clock;
  logic        reset_n;
  logic        set_flag;
  logic [16:0] set_time;
  logic        alarm_wr;
  logic [1:0]  alarm_sel;
  logic        alarm_en_in;
  logic [16:0] alarm_time_in;
  logic [3:0]  alarm_ack;
  logic [3:0]  alarm_snooze;
  logic [16:0] counter_state;
  logic        sec_tick;
  logic        day_wrap;
  logic [3:0]  alarm_state;
  logic        alarm_any;

  int n_chk = 0;
  int n_bad = 0;
  int ticks;
  logic [3:0] seen;

  alarm_clock_multi #(
    .CLKS_PER_SEC(2),
    .SECS_PER_DAY(86400),
    .NUM_ALARMS(4),
    .SNOOZE_SECS(3)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .set_flag(set_flag),
    .set_time(set_time),
    .alarm_wr(alarm_wr),
    .alarm_sel(alarm_sel),
    .alarm_en_in(alarm_en_in),
    .alarm_time_in(alarm_time_in),
    .alarm_ack(alarm_ack),
    .alarm_snooze(alarm_snooze),
    .counter_state(counter_state),
    .sec_tick(sec_tick),
    .day_wrap(day_wrap),
    .alarm_state(alarm_state),
    .alarm_any(alarm_any)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    ticks += int'(sec_tick);
    seen |= alarm_state;
  endtask

  task automatic run_to(input logic [16:0] tgt);
    int n;
    n = 0;
    while (counter_state !== tgt && n < 60) begin
      step();
      n++;
    end
    chk("reach", 32'(counter_state), 32'(tgt));
  endtask

  task automatic do_set(input logic [16:0] t);
    set_flag = 1'b1;
    set_time = t;
    step();
    set_flag = 1'b0;
  endtask

  task automatic wr(input logic [1:0] s,
                    input logic e,
                    input logic [16:0] t);
    alarm_wr = 1'b1;
    alarm_sel = s;
    alarm_en_in = e;
    alarm_time_in = t;
    step();
    alarm_wr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    set_flag = 1'b0;
    set_time = '0;
    alarm_wr = 1'b0;
    alarm_sel = '0;
    alarm_en_in = 1'b0;
    alarm_time_in = '0;
    alarm_ack = '0;
    alarm_snooze = '0;
    ticks = 0;
    seen = '0;
    #12;
    chk("rst_cnt", 32'(counter_state), 0);
    chk("rst_any", 32'(alarm_any), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    ticks = int'(sec_tick);
    for (int k = 0; k < 9; k++) step();
    chk("run10_cnt", 32'(counter_state), 5);
    chk("run10_ticks", 32'(ticks), 5);
    chk("run10_any", 32'(alarm_any), 0);

    ticks = 0;
    set_flag = 1'b1;
    set_time = 17'd34953;
    for (int k = 0; k < 4; k++) step();
    chk("set_hold", 32'(counter_state), 34953);
    chk("set_noticks", 32'(ticks), 0);
    set_flag = 1'b0;
    step();
    chk("rel_1", 32'(counter_state), 34953);
    step();
    chk("rel_2", 32'(counter_state), 34954);
    chk("rel_tick", 32'(sec_tick), 1);

    wr(2'd2, 1'b1, 17'd34957);
    run_to(17'd34956);
    chk("ch2_pre", 32'(alarm_state), 0);
    run_to(17'd34957);
    chk("ch2_ring", 32'(alarm_state), 4'b0100);
    chk("ch2_any", 32'(alarm_any), 1);
    alarm_ack = 4'b0100;
    step();
    alarm_ack = '0;
    chk("ch2_ack", 32'(alarm_state), 0);
    do_set(17'd34955);
    run_to(17'd34957);
    chk("ch2_again", 32'(alarm_state), 4'b0100);
    alarm_ack = 4'b0100;
    step();
    alarm_ack = '0;

    set_flag = 1'b1;
    set_time = 17'd50925;
    step();
    wr(2'd0, 1'b1, 17'd50925);
    step();
    set_flag = 1'b0;
    seen = '0;
    run_to(17'd50930);
    chk("set_nomatch", 32'(seen), 0);

    do_set(17'd90000);
    chk("set_oor", 32'(counter_state), 0);

    do_set(17'd86398);
    run_to(17'd86399);
    chk("wrap_pre", 32'(day_wrap), 0);
    run_to(17'd0);
    chk("wrap_pulse", 32'(day_wrap), 1);
    chk("wrap_tick", 32'(sec_tick), 1);
    step();
    chk("wrap_clr", 32'(day_wrap), 0);

    set_flag = 1'b1;
    set_time = 17'd98;
    step();
    wr(2'd1, 1'b1, 17'd100);
    set_flag = 1'b0;
    run_to(17'd100);
    chk("ch1_ring", 32'(alarm_state), 4'b0010);
    run_to(17'd101);
    chk("ch1_latch", 32'(alarm_state), 4'b0010);
    alarm_snooze = 4'b0010;
    step();
    alarm_snooze = '0;
    chk("snz_clr", 32'(alarm_state), 0);
    run_to(17'd103);
    chk("snz_wait", 32'(alarm_state), 0);
    run_to(17'd104);
    chk("snz_ring", 32'(alarm_state), 4'b0010);
    alarm_ack = 4'b0010;
    step();
    alarm_ack = '0;
    chk("snz_ack", 32'(alarm_state), 0);

    do_set(17'd98);
    run_to(17'd99);
    step();
    alarm_ack = 4'b0010;
    step();
    alarm_ack = '0;
    chk("ackmatch_cnt", 32'(counter_state), 100);
    chk("ackmatch", 32'(alarm_state), 4'b0010);
    alarm_ack = 4'b0010;
    step();
    alarm_ack = '0;

    wr(2'd3, 1'b1, 17'd1234);
    do_set(17'd1232);
    run_to(17'd1234);
    chk("ch3_ring", 32'(alarm_state), 4'b1000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(counter_state), 0);
    chk("arst_state", 32'(alarm_state), 0);
    chk("arst_any", 32'(alarm_any), 0);
    chk("arst_tick", 32'(sec_tick), 0);
    #3;
    reset_n = 1'b1;
    do_set(17'd1232);
    seen = '0;
    run_to(17'd1236);
    chk("cfg_cleared", 32'(seen), 0);

    $display("test done: total=%0d bad=%0d",
             n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_clock_multi.md
Name: alarm_clock_multi

Overview:
Parametrised next-generation timekeeper. Merges the seconds-of-day counter and alarm handling into one synchronous block, and adds:
- a clock prescaler,
- a configurable day length,
- NUM_ALARMS independent alarm channels, each with acknowledge and snooze.

It sits between the input-parsing logic (set/alarm commands) and the output formatter, which consumes counter_state and alarm_state.

Parameters:
CLKS_PER_SEC, 2, clock cycles per second tick (>=1)
SECS_PER_DAY, 86400, counter modulus; counter runs 0..SECS_PER_DAY-1
NUM_ALARMS, 4, number of alarm channels (>=1)
SNOOZE_SECS, 540, snooze delay in seconds (<SECS_PER_DAY)
Derived: CW = clog2(SECS_PER_DAY) (17 at default); AW = max(1, clog2(NUM_ALARMS))

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
set_flag  in  1  level; hold counter at set_time while high
set_time  in  CW  time loaded while set_flag high
alarm_wr  in  1  one-cycle write strobe for the alarm config selected by alarm_sel
alarm_sel  in  AW  channel index for alarm_wr
alarm_en_in  in  1  enable value written
alarm_time_in  in  CW  alarm time written
alarm_ack  in  NUM_ALARMS  per-channel dismiss, level-sampled
alarm_snooze  in  NUM_ALARMS  per-channel snooze request, level-sampled
counter_state  out  CW  current seconds-of-day, registered
sec_tick  out  1  one-cycle pulse coincident with each counter increment
day_wrap  out  1  one-cycle pulse when counter wraps SECS_PER_DAY-1 -> 0
alarm_state  out  NUM_ALARMS  per-channel ringing flag, registered
alarm_any  out  1  OR of alarm_state

Behaviour:
- Reset (reset_n low, no clock edge needed):
  - counter_state, prescaler, sec_tick, day_wrap, and all alarm_state bits go to 0.
  - All channel enables, alarm times, and snooze-pending flags are cleared.
- Prescaler counts 0..CLKS_PER_SEC-1. On the edge where it equals CLKS_PER_SEC-1 and set_flag is low:
  - prescaler returns to 0;
  - counter increments, wrapping from SECS_PER_DAY-1 to 0;
  - sec_tick is 1 for that cycle;
  - day_wrap is 1 for that cycle on a wrap.
- set_flag high: every edge loads counter_state <= set_time and clears the prescaler. No ticks and no alarm matches occur.
  - set_time >= SECS_PER_DAY loads 0.
  - After release, the first increment happens CLKS_PER_SEC edges later.
- Match: channel i asserts alarm_state[i] on the increment edge whose new counter value equals alarm_time[i] and whose channel is enabled.
  - Loads via set_flag never match. Setting the clock onto an alarm time therefore does not ring, even after release; the alarm fires on the next pass.
- Snooze target: when snooze_pend[i] is set and the incremented value equals snooze_time[i], alarm_state[i] reasserts and snooze_pend[i] clears.
- alarm_wr: writes alarm_en[i] and alarm_time[i], and clears alarm_state[i] and snooze_pend[i], where i = alarm_sel.
  - alarm_sel >= NUM_ALARMS: write ignored.
  - alarm_time_in >= SECS_PER_DAY: channel written with enable forced to 0.
- alarm_ack[i]: clears alarm_state[i] and snooze_pend[i] on the next edge.
- alarm_snooze[i] while alarm_state[i]=1:
  - clears alarm_state[i];
  - sets snooze_pend[i];
  - sets snooze_time[i] = (counter_state + SNOOZE_SECS) mod SECS_PER_DAY, computed in CW+1 bits.
  - Ignored when alarm_state[i]=0.
- Per-channel priority, same cycle: reset > alarm_wr > match/snooze-target assertion > ack > snooze. A new match is never lost to a simultaneous ack.
- alarm_state[i] stays set (latched) until ack, snooze, alarm_wr, or reset. Repeated matches while set have no effect.
- Disabling a channel (alarm_wr with en=0) cancels any pending snooze.
- alarm_any is the combinational OR of registered alarm_state bits.

Test Plan:
- Reset released, 10 edges, defaults -> counter_state = 5, five single-cycle sec_tick pulses, alarm_any = 0.
- set_flag high 4 edges with set_time = 34953 -> counter held at 34953, no sec_tick; release -> 34954 exactly 2 edges later.
- Write ch2 {en=1, time=34957}, counter running from 34953 -> alarm_state = 4'b0100 on the edge counter becomes 34957; alarm_ack[2] -> 0 next edge; next day match re-rings.
- Set 50925 with ch0 {en=1, time=50925} written during set, then release -> no ring through 50930; set 86398 -> day_wrap pulse on 86399 -> 0.
- SNOOZE_SECS = 3, ch1 rings at 100, alarm_snooze[1] at 101 -> alarm_state[1] = 0 and reasserts when counter = 104; ack at the same edge as a match -> bit stays 1.
- counter = 1234, ch3 ringing, reset_n pulled low between edges -> all outputs 0 immediately; after release no ringing at 1234 (config cleared).
